hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage CPU. It sits beside the ID/EX boundary and drives several controls:
- PC and IF/ID stall enables, the ID/EX bubble and the IF/ID flush;
- the registered forwarding selects consumed by the EX-stage operand muxes.

It sequences load-use stalls, branch flushes and the multi-cycle mult/div unit. Forwarding encoding is unchanged: 2'b10 = EX/MEM result, 2'b01 = MEM/WB result, 2'b00 = register file.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_select.sv | 39 +++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, hazard FSM states
// and the default register index width.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } hazard_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Dual source-operand compare against the EX and MEM destinations; produces the
// forwarding selects the ID instruction will need once it reaches EX.
module fwd_select #(
    parameter int REG_W = hazard_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             regwrite_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             regwrite_mem,
    output logic [1:0]       fa_next,
    output logic [1:0]       fb_next
);
    import hazard_ctrl_pkg::*;

    logic ex_valid;
    logic mem_valid;

    // r0 is hardwired to zero, so a write to it must never be forwarded.
    assign ex_valid  = regwrite_ex  && (rd_ex  != '0);
    assign mem_valid = regwrite_mem && (rd_mem != '0);

    // The younger (EX) producer wins over the older (MEM) one.
    function automatic logic [1:0] pick(input logic [REG_W-1:0] src);
        if (ex_valid && (rd_ex == src)) begin
            return FWD_EXMEM;
        end else if (mem_valid && (rd_mem == src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fa_next = pick(rs_id);
        fb_next = pick(rt_id);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch flush,
// mult/div occupancy FSM and registered EX-stage forwarding selects.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int REG_W  = hazard_ctrl_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             md_start_id,
    input  logic             md_use_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             regwrite_ex,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic             regwrite_mem,
    input  logic             branch_taken_ex,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             md_busy
);
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = $clog2(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

    hazard_state_e    state;
    logic [CNT_W-1:0] cnt;

    logic       load_use;
    logic       md_hazard;
    logic       stall;
    logic       md_issue;
    logic [1:0] fa_next;
    logic [1:0] fb_next;

    fwd_select #(.REG_W(REG_W)) u_fwd_select (
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .rd_ex       (rd_ex),
        .regwrite_ex (regwrite_ex),
        .rd_mem      (rd_mem),
        .regwrite_mem(regwrite_mem),
        .fa_next     (fa_next),
        .fb_next     (fb_next)
    );

    assign md_busy   = (state == MD_BUSY);
    assign load_use  = memread_ex && (rd_ex != '0) &&
                       ((use_rs_id && (rd_ex == rs_id)) || (use_rt_id && (rd_ex == rt_id)));
    assign md_hazard = md_busy && md_use_id;
    assign stall     = load_use || md_hazard;
    // A flushed or stalled mult/div is not issued; it is retried later.
    assign md_issue  = md_start_id && !stall && !branch_taken_ex;

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (!rst) begin
            if (branch_taken_ex) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            forward_a <= FWD_RF;
            forward_b <= FWD_RF;
        end else begin
            // A bubble carries no operands, so it must not inherit a select.
            forward_a <= idex_bubble ? FWD_RF : fa_next;
            forward_b <= idex_bubble ? FWD_RF : fb_next;

            unique case (state)
                IDLE: begin
                    if (md_issue) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    // The issued op is past ID, so a branch flush does not stop it.
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    a_flush_not_stall: assert property (@(posedge clk) disable iff (rst)
        !(ifid_flush && (pc_stall || ifid_stall)));
    a_busy_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
        md_busy |-> (cnt != '0));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expected values.
module tb_hazard_ctrl;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             md_start_id;
    logic             md_use_id;
    logic [REG_W-1:0] rd_ex;
    logic             regwrite_ex;
    logic             memread_ex;
    logic [REG_W-1:0] rd_mem;
    logic             regwrite_mem;
    logic             branch_taken_ex;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             md_busy;

    int n_vec;
    int n_err;

    hazard_ctrl #(.MD_LAT(MD_LAT), .REG_W(REG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs_id          (rs_id),
        .rt_id          (rt_id),
        .use_rs_id      (use_rs_id),
        .use_rt_id      (use_rt_id),
        .md_start_id    (md_start_id),
        .md_use_id      (md_use_id),
        .rd_ex          (rd_ex),
        .regwrite_ex    (regwrite_ex),
        .memread_ex     (memread_ex),
        .rd_mem         (rd_mem),
        .regwrite_mem   (regwrite_mem),
        .branch_taken_ex(branch_taken_ex),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .idex_bubble    (idex_bubble),
        .ifid_flush     (ifid_flush),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .md_busy        (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control bundle order: {pc_stall, ifid_stall, idex_bubble, ifid_flush}.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, pc_stall, ifid_stall, idex_bubble, ifid_flush}, {28'd0, exp});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
        check(tag, {28'd0, forward_a, forward_b}, {28'd0, exp_a, exp_b});
    endtask

    task automatic idle_inputs();
        rs_id = '0; rt_id = '0; use_rs_id = 1'b0; use_rt_id = 1'b0;
        md_start_id = 1'b0; md_use_id = 1'b0;
        rd_ex = '0; regwrite_ex = 1'b0; memread_ex = 1'b0;
        rd_mem = '0; regwrite_mem = 1'b0; branch_taken_ex = 1'b0;
    endtask

    // Advance one edge and land just after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;

        // Reset: hazard-causing inputs must not leak through while rst=1.
        #1;
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd2; rs_id = 5'd2; use_rs_id = 1'b1;
        md_start_id = 1'b1;
        settle();
        check_ctl("rst_ctl", 4'b0000);
        tick();
        check_fwd("rst_fwd", 2'b00, 2'b00);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();

        // Load-use on rs: one stall cycle, bubble kills the EX-match select.
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd2;
        rs_id = 5'd2; use_rs_id = 1'b1; rt_id = 5'd5; use_rt_id = 1'b1;
        settle();
        check_ctl("lu_stall", 4'b1110);
        tick();
        check_fwd("lu_bubble_fwd", 2'b00, 2'b00);
        memread_ex = 1'b0; regwrite_ex = 1'b0; rd_ex = 5'd0;
        rd_mem = 5'd2; regwrite_mem = 1'b1;
        settle();
        check_ctl("lu_release", 4'b0000);
        tick();
        check_fwd("lu_memwb_fwd", 2'b01, 2'b00);

        // Load-use via rt; then same regs with use_rt_id=0; then load to r0.
        idle_inputs();
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd7; rt_id = 5'd7; use_rt_id = 1'b1;
        settle();
        check_ctl("lu_rt_stall", 4'b1110);
        use_rt_id = 1'b0;
        settle();
        check_ctl("lu_rt_unused", 4'b0000);
        rd_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; use_rs_id = 1'b1; use_rt_id = 1'b1;
        settle();
        check_ctl("lu_r0", 4'b0000);
        tick();

        // EX match beats MEM match; rt=0 never forwards.
        idle_inputs();
        regwrite_ex = 1'b1; rd_ex = 5'd3; regwrite_mem = 1'b1; rd_mem = 5'd3;
        rs_id = 5'd3; rt_id = 5'd0; use_rs_id = 1'b1;
        tick();
        check_fwd("fwd_ex_prio", 2'b10, 2'b00);
        rd_ex = 5'd0; rd_mem = 5'd0; rs_id = 5'd0;
        tick();
        check_fwd("fwd_r0", 2'b00, 2'b00);

        // MEM-only match on rt with use flags low; EX without regwrite ignored.
        idle_inputs();
        regwrite_mem = 1'b1; rd_mem = 5'd9; rt_id = 5'd9;
        rd_ex = 5'd4; regwrite_ex = 1'b0; rs_id = 5'd4;
        tick();
        check_fwd("fwd_mem_rt", 2'b00, 2'b01);

        // Mult/div issue, then mfhi stalls exactly MD_LAT-1 cycles.
        idle_inputs();
        md_start_id = 1'b1; md_use_id = 1'b1;
        settle();
        check_ctl("md_issue_ctl", 4'b0000);
        tick();
        md_start_id = 1'b0;
        for (int i = 0; i < MD_LAT - 1; i++) begin
            settle();
            check("md_busy_on", {31'd0, md_busy}, 32'd1);
            check_ctl("mfhi_stall", 4'b1110);
            tick();
        end
        check("md_busy_off", {31'd0, md_busy}, 32'd0);
        check_ctl("mfhi_issue", 4'b0000);
        tick();

        // Back-to-back mult/div: second waits until IDLE, then issues.
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        for (int i = 0; i < MD_LAT - 1; i++) begin
            settle();
            check_ctl("md2_stall", 4'b1110);
            tick();
        end
        check("md2_idle", {31'd0, md_busy}, 32'd0);
        tick();
        check("md2_issued", {31'd0, md_busy}, 32'd1);
        idle_inputs();
        tick();
        tick();
        check("md2_last", {31'd0, md_busy}, 32'd1);
        tick();
        check("md2_done", {31'd0, md_busy}, 32'd0);

        // Branch with mult/div start: flush wins, nothing issues.
        md_start_id = 1'b1; md_use_id = 1'b1; branch_taken_ex = 1'b1;
        settle();
        check_ctl("br_md_ctl", 4'b0011);
        tick();
        check("br_md_noissue", {31'd0, md_busy}, 32'd0);

        // Branch during MD_BUSY: flush overrides the stall, counting continues.
        idle_inputs();
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        md_start_id = 1'b0; branch_taken_ex = 1'b1;
        settle();
        check_ctl("br_busy_ctl", 4'b0011);
        tick();
        idle_inputs();
        tick();
        check("br_busy_c3", {31'd0, md_busy}, 32'd1);
        tick();
        check("br_busy_done", {31'd0, md_busy}, 32'd0);

        // Branch concurrent with load-use: flush, and both selects cleared.
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd2; rs_id = 5'd2; use_rs_id = 1'b1;
        rt_id = 5'd6; rd_mem = 5'd6; regwrite_mem = 1'b1; branch_taken_ex = 1'b1;
        settle();
        check_ctl("br_lu_ctl", 4'b0011);
        tick();
        check_fwd("br_lu_fwd", 2'b00, 2'b00);

        // Reset in the second busy cycle, then normal operation resumes.
        idle_inputs();
        regwrite_mem = 1'b1; rd_mem = 5'd8; rs_id = 5'd8; rt_id = 5'd8;
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        md_start_id = 1'b0;
        tick();
        check("rst_mid_busy", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        settle();
        check_ctl("rst_mid_ctl", 4'b0000);
        tick();
        check("rst_mid_idle", {31'd0, md_busy}, 32'd0);
        check_fwd("rst_mid_fwd", 2'b00, 2'b00);
        rst = 1'b0;
        idle_inputs();
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd4; rt_id = 5'd4; use_rt_id = 1'b1;
        settle();
        check_ctl("post_rst_lu", 4'b1110);
        tick();
        idle_inputs();
        md_start_id = 1'b1; md_use_id = 1'b1;
        tick();
        check("post_rst_md", {31'd0, md_busy}, 32'd1);
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
